// File: rtl/add_sub_32_result_fifo.sv
// Result-capture FIFO downstream of add_sub_32: derives {Z,N,C,V} for each valid sum,
// buffers sum+flags for a valid/ready consumer, and counts results lost while full.
module add_sub_32_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [31:0]              S,
    input  logic                     Co,
    input  logic                     a_msb,
    input  logic                     b_msb,
    input  logic                     subtract,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_sum,
    output logic [3:0]               out_flags,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Overflow rule differs for subtract: operands of unlike sign can overflow there.
    function automatic logic [3:0] calc_flags(
        input logic [31:0] s,
        input logic        co,
        input logic        a,
        input logic        b,
        input logic        sub
    );
        logic v;
        v = sub ? ((a != b) && (s[31] != a)) : ((a == b) && (s[31] != a));
        return {(s == 32'd0), s[31], co, v};
    endfunction

    logic [35:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [3:0]    flags_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;

    assign flags_s   = calc_flags(S, Co, a_msb, b_msb, subtract);
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != {CW{1'b0}});
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign drop_s    = in_valid && !in_ready;
    assign {out_flags, out_sum} = mem_r[rd_ptr_r];

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {flags_s, S};
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count    <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Saturating drop counter; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= {CNT_W{1'b0}};
        end else if (drop_s && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/add_sub_32_result_fifo.md
# add_sub_32_result_fifo

Result-capture stage that sits directly downstream of `add_sub_32`. Each cycle the adder marks as valid, it takes the 32-bit sum `S` and carry-out `Co`, derives the status flags, and pushes the result into a small FIFO. A consumer drains the FIFO through a valid/ready handshake. Results the FIFO cannot accept are dropped and counted, because the adder has no back-pressure.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, minimum 2.
- `CNT_W`, default 8: width of the saturating drop counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: `S`/`Co` from `add_sub_32` are valid this cycle.
- `S` in 32: adder sum.
- `Co` in 1: adder carry-out.
- `a_msb` in 1: bit 31 of operand `A` that produced `S`.
- `b_msb` in 1: bit 31 of operand `B` that produced `S`.
- `subtract` in 1: the `Subtract` control that produced `S`.
- `in_ready` out 1: FIFO can accept a push.
- `out_valid` out 1: head entry available.
- `out_sum` out 32: head sum.
- `out_flags` out 4: head flags {Z, N, C, V} (bit 3 = Z).
- `out_ready` in 1: consumer accepts the head.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `drop_cnt` out CNT_W: number of results dropped.

## Operation
- Flags are computed combinationally at the input and stored with the sum:
  - Z = (S == 0).
  - N = S[31].
  - C = Co, passed through raw. No inversion for subtract.
  - V when `subtract`=0: (a_msb == b_msb) && (S[31] != a_msb).
  - V when `subtract`=1: (a_msb != b_msb) && (S[31] != a_msb).
- Push occurs when `in_valid && in_ready`. `in_ready = (count != DEPTH)`.
  - There is no fall-through when full: a pop in the same cycle does not enable a push.
- Pop occurs when `out_valid && out_ready`. `out_valid = (count != 0)`.
- `out_sum`/`out_flags` are read combinationally from the register array at `rd_ptr`. Their value is don't-care while `out_valid`=0.
- Pointers:
  - `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - `count` increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- Drop: when `in_valid && !in_ready`, `drop_cnt` increments, saturating at 2^CNT_W−1. It never wraps and clears only on reset.
- Storage array contents are not reset. The pointers, `count` and `drop_cnt` are reset.

## Timing
- Reset (`rst_n`=0, asynchronous) sets:
  - `wr_ptr`=`rd_ptr`=0 and `count`=0.
  - `out_valid`=0, `in_ready`=1, `drop_cnt`=0.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge. The first push after release is accepted on the first rising edge with `rst_n`=1.
- Latency:
  - A push on edge n gives `out_valid`=1 with that entry's data after edge n, i.e. visible in cycle n+1.
  - `out_valid` never combinationally follows `in_valid`.
- Handshake:
  - The consumer may hold `out_ready` high continuously.
  - Data at the head stays stable while `out_valid`=1 and `out_ready`=0.
- Full (`count`=DEPTH):
  - `in_ready`=0.
  - A simultaneous `in_valid`+pop pops only, drops the input, and increments `drop_cnt`.
  - `in_ready` returns to 1 the cycle after the pop.
- Empty: `out_ready` is ignored and no pointer moves.
- Throughput: one push and one pop per cycle in steady state when not full.

## Test plan
- Reset, then S=30, Co=0, a_msb=0, b_msb=0, subtract=0 for one cycle -> next cycle `out_valid`=1, `out_sum`=0x0000001E, flags Z0 N0 C0 V0; pop -> `count`=0.
- S=0xFFFFFFF6, Co=0, subtract=1, a_msb=0, b_msb=0 (10−20) -> N=1, Z=0, V=0; S=0, Co=1, subtract=1 -> Z=1, C=1.
- S=0x80000000, a_msb=0, b_msb=0, subtract=0 (0x7FFFFFFF+1) -> V=1, N=1; S=0x7FFFFFFF, a_msb=1, b_msb=0, subtract=1 -> V=1.
- `out_ready`=0, push 5 consecutive values 1..5 -> `count`=4, `in_ready`=0, `drop_cnt`=1; then `out_ready`=1 -> outputs 1,2,3,4 in order, value 5 never appears, pointers wrap correctly on a refill of 4.
- Full FIFO with `in_valid`=1 and `out_ready`=1 in the same cycle -> one pop, no push, `drop_cnt`+1, `count`=3; next cycle `in_ready`=1.
- FIFO holding 3 entries, pull `rst_n` low between clock edges -> `out_valid`=0, `count`=0, `drop_cnt`=0 immediately; after release, push 0xA5 -> it is the first value out.
